s5s_dpr_arb: RTL and testbench
==============================

Name: s5s_dpr_arb

Overview:
Round-robin arbiter that shares a single DPR target (req/cmd/rdy port) between NREQ upstream requesters. Each requester issues a one-cycle req pulse with a cmd. The arbiter stores the request, replays it downstream as a protocol-clean one-cycle m_req with m_cmd held stable until m_rdy, then returns rdy to the owning requester. Only one request is outstanding downstream at a time. A watchdog aborts a transaction when rdy never arrives.

Parameters:
NREQ, 4, number of upstream requesters (2..16)
CMD_W, 2, command width
TIMEOUT, 256, max cycles in WAIT before abort; 0 disables the watchdog
OWN_W, $clog2(NREQ), width of the owner index (localparam)

Ports:
clk  input  1  clock; all logic on posedge
rstn  input  1  asynchronous active-low reset
s_req  input  NREQ  per-requester one-cycle request pulse
s_cmd  input  NREQ*CMD_W  per-requester command; slice i = [i*CMD_W +: CMD_W], sampled with s_req[i]
s_rdy  output  NREQ  per-requester one-cycle completion pulse
s_err  output  NREQ  asserted together with s_rdy[i] when the transaction was aborted by timeout
m_req  output  1  downstream one-cycle request pulse
m_cmd  output  CMD_W  downstream command; stable from m_req until the m_rdy cycle inclusive
m_rdy  input  1  downstream completion pulse
busy  output  1  high while in WAIT
owner  output  OWN_W  index of the current or last granted requester
timeout_seen  output  1  sticky; set on any watchdog abort; cleared only by reset

Behaviour:
- Reset (async, rstn=0): state=IDLE, pend=0, cmd_q=0, rr_ptr=0, m_req=0, m_cmd=0, s_rdy=0, s_err=0, owner=0, busy=0, timeout_seen=0, wd_cnt=0. Reset mid-WAIT drops all requests silently; no s_rdy is generated.
- Capture: s_req[i]=1 with pend[i]=0 → pend[i]<=1, cmd_q[i]<=s_cmd slice. s_req[i] while pend[i]=1 is a protocol violation and is ignored; cmd_q[i] is unchanged.
- Pick: combinational. First i with pend[i]=1 searching rr_ptr, rr_ptr+1, ..., NREQ-1, then wrapping to 0.
- IDLE: if pend!=0 → owner<=pick, m_req<=1, m_cmd<=cmd_q[pick], wd_cnt<=0, state<=WAIT. Otherwise hold.
- Latency: s_req at cycle t → m_req at cycle t+2, minimum.
- WAIT:
  - m_req<=0. m_cmd holds. wd_cnt increments.
  - On m_rdy, in any cycle after the m_req cycle: s_rdy[owner]<=1 for one cycle, pend[owner]<=0, rr_ptr<=(owner+1) mod NREQ, state<=IDLE.
  - m_rdy in the same cycle as m_req is ignored, because the target is required to answer at the earliest one cycle later.
- Timeout (TIMEOUT>0): if wd_cnt==TIMEOUT-1 and m_rdy=0 → s_rdy[owner]<=1, s_err[owner]<=1, timeout_seen<=1, pend[owner]<=0, rr_ptr advances, state<=IDLE. If m_rdy coincides with the timeout cycle, the transaction completes normally (s_err=0).
- m_rdy while in IDLE is ignored.
- Back-to-back: IDLE can issue the next m_req in the cycle after completion. Minimum downstream spacing is therefore m_req, m_rdy, one IDLE cycle, m_req.
- Completion vs. new request: a requester may re-request in the cycle s_rdy[i] is high, because pend[i] is already clear.
- A new s_req[j] arriving during WAIT is captured and waits its turn.
- Fairness: a requester that is pending is granted within NREQ transactions.
- All outputs are registered.

Decomposition:
- Package s5s_dpr_pkg holds:
  - the state enum (IDLE, WAIT) as logic[0:0];
  - CMD_W default;
  - DPR command encodings (shared with the interface and agents).
- Sub-module s5s_dpr_rr_pick: combinational round-robin picker with inputs pend[NREQ] and ptr[OWN_W], outputs valid and idx[OWN_W].
- The arbiter instantiates the picker and holds the FSM, pend/cmd_q registers and watchdog.

Test Plan:
1. Single request: s_req[2]=1, s_cmd[2]=2'b10 at cycle 0.
   → m_req=1, m_cmd=2'b10 at cycle 2.
   → m_rdy at cycle 5 gives s_rdy[2]=1 at cycle 6, s_err=0, owner=2.
2. Simultaneous requests: s_req=4'b1111 in one cycle with cmds 0,1,2,3, rr_ptr=0, target answers after 1 cycle.
   → grants in order 0,1,2,3.
   → m_cmd follows 0,1,2,3.
   → m_cmd is stable throughout each WAIT.
3. Round-robin wrap: rr_ptr=3 after granting requester 2; pend=4'b1001.
   → requester 3 is granted, then requester 0.
4. Timeout: TIMEOUT=8, request from requester 1, m_rdy never asserted.
   → s_rdy[1]=1 and s_err[1]=1 exactly 8 cycles after the m_req cycle.
   → timeout_seen=1 and stays 1.
   → the next pending request is issued afterwards.
5. Protocol violations:
   - Repeat s_req[0] with a new cmd while pend[0]=1 → the original cmd is issued; only one m_req for requester 0.
   - m_rdy in IDLE → no s_rdy.
6. Reset mid-WAIT: rstn=0 for 2 cycles during WAIT.
   → all outputs return to reset values immediately.
   → no s_rdy pulse.
   → a subsequent request completes normally.

Source files
------------

// File: rtl/s5s_dpr_pkg.sv
// Shared types and constants for the DPR round-robin arbiter.
// Holds the FSM state type, the default command width and the DPR command encodings.
package s5s_dpr_pkg;

    localparam int DPR_CMD_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [DPR_CMD_W-1:0] DPR_CMD_NOP = 2'b00;
    localparam logic [DPR_CMD_W-1:0] DPR_CMD_RD  = 2'b01;
    localparam logic [DPR_CMD_W-1:0] DPR_CMD_WR  = 2'b10;
    localparam logic [DPR_CMD_W-1:0] DPR_CMD_RMW = 2'b11;

    // Owner index width; a 1-bit index is kept even for degenerate sizes.
    function automatic int own_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/s5s_dpr_arb_if.sv
// Bundle of upstream requester and downstream DPR target signals around the arbiter.
// The slave modport is the arbiter's view; master is the requester/target side.
interface s5s_dpr_arb_if
    import s5s_dpr_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CMD_W = DPR_CMD_W
);
    localparam int OWN_W = own_w(NREQ);

    logic [NREQ-1:0]       s_req;
    logic [NREQ*CMD_W-1:0] s_cmd;
    logic [NREQ-1:0]       s_rdy;
    logic [NREQ-1:0]       s_err;
    logic                  m_req;
    logic [CMD_W-1:0]      m_cmd;
    logic                  m_rdy;
    logic                  busy;
    logic [OWN_W-1:0]      owner;
    logic                  timeout_seen;

    modport master (
        output s_req, s_cmd, m_rdy,
        input  s_rdy, s_err, m_req, m_cmd, busy, owner, timeout_seen
    );

    modport slave (
        input  s_req, s_cmd, m_rdy,
        output s_rdy, s_err, m_req, m_cmd, busy, owner, timeout_seen
    );

endinterface

// File: rtl/s5s_dpr_rr_pick.sv
// Combinational round-robin picker: first pending slot at or after ptr_i, wrapping.
// valid_o is low when nothing is pending; idx_o is then zero.
module s5s_dpr_rr_pick
    import s5s_dpr_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int OWN_W = own_w(NREQ)
) (
    input  logic [NREQ-1:0]  pend_i,
    input  logic [OWN_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [OWN_W-1:0] idx_o
);

    function automatic logic [OWN_W-1:0] slot(input logic [OWN_W-1:0] ptr, input int k);
        int s;
        s = (int'(ptr) + k) % NREQ;
        return OWN_W'(s);
    endfunction

    // Walk offsets from the far end back to zero so the nearest pending slot wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (pend_i[slot(ptr_i, k)]) begin
                valid_o = 1'b1;
                idx_o   = slot(ptr_i, k);
            end
        end
    end

endmodule

// File: rtl/s5s_dpr_arb.sv
// Round-robin arbiter sharing one DPR target among NREQ requesters, one transaction at a time.
// Requests are latched per requester, replayed downstream, and aborted by a watchdog on silence.
module s5s_dpr_arb
    import s5s_dpr_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CMD_W   = DPR_CMD_W,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rstn,
    s5s_dpr_arb_if.slave  bus
);

    localparam int OWN_W = own_w(NREQ);
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e                     state_q, state_d;
    logic [NREQ-1:0]            pend_q, pend_d;
    logic [NREQ-1:0][CMD_W-1:0] cmd_q, cmd_d;
    logic [OWN_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [OWN_W-1:0]           owner_q, owner_d;
    logic                       m_req_q, m_req_d;
    logic [CMD_W-1:0]           m_cmd_q, m_cmd_d;
    logic [NREQ-1:0]            s_rdy_q, s_rdy_d;
    logic [NREQ-1:0]            s_err_q, s_err_d;
    logic                       timeout_seen_q, timeout_seen_d;
    logic [WD_W-1:0]            wd_cnt_q, wd_cnt_d;

    logic                       pick_valid;
    logic [OWN_W-1:0]           pick_idx;
    logic                       rsp_ok;
    logic                       wd_fire;

    s5s_dpr_rr_pick #(
        .NREQ  (NREQ),
        .OWN_W (OWN_W)
    ) u_pick (
        .pend_i  (pend_q),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // The target may only answer from the cycle after m_req onwards.
    assign rsp_ok  = bus.m_rdy && !m_req_q;
    assign wd_fire = (TIMEOUT > 0) && (wd_cnt_q == WD_W'(TIMEOUT - 1)) && !rsp_ok;

    function automatic logic [OWN_W-1:0] next_ptr(input logic [OWN_W-1:0] cur);
        return (cur == OWN_W'(NREQ - 1)) ? '0 : cur + 1'b1;
    endfunction

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q | (bus.s_req & ~pend_q);
        cmd_d          = cmd_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        m_req_d        = 1'b0;
        m_cmd_d        = m_cmd_q;
        s_rdy_d        = '0;
        s_err_d        = '0;
        timeout_seen_d = timeout_seen_q;
        wd_cnt_d       = wd_cnt_q;

        for (int i = 0; i < NREQ; i++) begin
            if (bus.s_req[i] && !pend_q[i]) begin
                cmd_d[i] = bus.s_cmd[i*CMD_W +: CMD_W];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d  = pick_idx;
                    m_req_d  = 1'b1;
                    m_cmd_d  = cmd_q[pick_idx];
                    wd_cnt_d = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                // A normal answer in the watchdog's last cycle still wins over the abort.
                if (rsp_ok || wd_fire) begin
                    s_rdy_d[owner_q] = 1'b1;
                    s_err_d[owner_q] = wd_fire;
                    timeout_seen_d   = timeout_seen_q | wd_fire;
                    pend_d[owner_q]  = 1'b0;
                    rr_ptr_d         = next_ptr(owner_q);
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            pend_q         <= '0;
            cmd_q          <= '0;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            m_req_q        <= 1'b0;
            m_cmd_q        <= '0;
            s_rdy_q        <= '0;
            s_err_q        <= '0;
            timeout_seen_q <= 1'b0;
            wd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            cmd_q          <= cmd_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            m_req_q        <= m_req_d;
            m_cmd_q        <= m_cmd_d;
            s_rdy_q        <= s_rdy_d;
            s_err_q        <= s_err_d;
            timeout_seen_q <= timeout_seen_d;
            wd_cnt_q       <= wd_cnt_d;
        end
    end

    assign bus.s_rdy        = s_rdy_q;
    assign bus.s_err        = s_err_q;
    assign bus.m_req        = m_req_q;
    assign bus.m_cmd        = m_cmd_q;
    assign bus.busy         = (state_q == WAIT);
    assign bus.owner        = owner_q;
    assign bus.timeout_seen = timeout_seen_q;

endmodule

// File: tb/tb_s5s_dpr_arb.sv
// Scoreboard bench for s5s_dpr_arb: the driver predicts grant order from a round-robin model,
// a reactive target answers m_req, and a separate monitor checks every grant and completion.
module tb_s5s_dpr_arb;

    localparam int NREQ    = 4;
    localparam int CMD_W   = 2;
    localparam int TIMEOUT = 8;

    typedef struct {
        int idx;
        int cmd;
        bit err;
        int lat;
        int expCycle;
    } exp_t;

    typedef struct {
        bit stall;
        int delay;
    } plan_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   nCompared;
    int   nMismatched;

    exp_t  expQ[$];
    plan_t planQ[$];
    exp_t  cur;
    bit    curActive;
    int    reqCycle;
    bit    mTimeoutSeen;
    int    mPtr;

    bit [3:0] rBatch;
    bit [7:0] rCmds;
    bit       rInj;
    int       rInjIdx;
    bit [1:0] rInjCmd;
    bit       rViol;
    int       rViolIdx;
    bit [1:0] rViolCmd;
    int       waitN;

    s5s_dpr_arb_if #(.NREQ(NREQ), .CMD_W(CMD_W)) bus ();

    s5s_dpr_arb #(
        .NREQ    (NREQ),
        .CMD_W   (CMD_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Round-robin rule: first pending requester at ptr, ptr+1, ... wrapping.
    function automatic int pickNext(input bit [3:0] pend, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // fixedDelay: 0 = random answer delay or stall, >0 = that delay, <0 = never answer.
    task automatic applyStimulus(input bit [3:0] batch, input bit [7:0] cmds,
                                 input bit doInj, input int injIdx, input bit [1:0] injCmd,
                                 input bit doViol, input int violIdx, input bit [1:0] violCmd,
                                 input int fixedDelay);
        bit [3:0] pend;
        bit [1:0] mCmd [4];
        bit       injPending;
        bit       first;
        int       g;
        exp_t     e;
        plan_t    p;
        bit [7:0] noise;

        for (int i = 0; i < NREQ; i++) mCmd[i] = cmds[i*2 +: 2];
        if (doInj) mCmd[injIdx] = injCmd;
        pend       = batch;
        injPending = doInj;
        first      = 1'b1;

        @(negedge clk);
        while (pend != 4'b0000) begin
            g       = pickNext(pend, mPtr);
            pend[g] = 1'b0;
            mPtr    = (g + 1) % NREQ;
            p.stall = (fixedDelay < 0) || (fixedDelay == 0 && $urandom_range(0, 4) == 0);
            p.delay = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, 7));
            e.idx      = g;
            e.cmd      = int'(mCmd[g]);
            e.err      = p.stall;
            e.lat      = p.stall ? TIMEOUT : p.delay + 1;
            e.expCycle = first ? cyc + 2 : -1;
            expQ.push_back(e);
            planQ.push_back(p);
            first = 1'b0;
            if (injPending) begin
                pend[injIdx] = 1'b1;
                injPending   = 1'b0;
            end
        end

        bus.s_req = batch;
        bus.s_cmd = cmds;
        @(negedge clk);
        noise     = 8'($urandom);
        bus.s_req = doViol ? 4'(1 << violIdx) : 4'b0000;
        noise[violIdx*2 +: 2] = violCmd;
        bus.s_cmd = noise;
        @(negedge clk);
        noise     = 8'($urandom);
        bus.s_req = doInj ? 4'(1 << injIdx) : 4'b0000;
        noise[injIdx*2 +: 2] = injCmd;
        bus.s_cmd = noise;
        @(negedge clk);
        bus.s_req = 4'b0000;

        waitN = 0;
        while ((expQ.size() != 0 || curActive) && waitN < 400) begin
            @(negedge clk);
            waitN++;
        end
        checkOutput("drain_bound", waitN < 400, 1);
        repeat (2) @(negedge clk);
        checkOutput("busy_idle", bus.busy, 0);
    endtask

    // Reactive DPR target: answers after the planned delay, or stays silent on a stall plan.
    initial begin
        int    mode;
        int    left;
        plan_t p;
        mode = 0;
        left = 0;
        bus.m_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bus.m_rdy = 1'b0;
                mode = 0;
            end else if (bus.m_req) begin
                if (planQ.size() > 0) begin
                    p    = planQ.pop_front();
                    mode = p.stall ? 2 : 1;
                    left = p.delay;
                end else begin
                    mode = 2;
                end
                bus.m_rdy = ($urandom_range(0, 3) == 0);
            end else if (mode == 1) begin
                left--;
                bus.m_rdy = (left == 0);
                if (left == 0) mode = 0;
            end else if (mode == 2) begin
                bus.m_rdy = 1'b0;
                if (bus.s_rdy != '0) mode = 0;
            end else begin
                bus.m_rdy = ($urandom_range(0, 5) == 0);
            end
        end
    end

    // Monitor: pops the expected grant on every m_req and checks it through to s_rdy.
    initial begin
        curActive = 1'b0;
        reqCycle  = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                curActive = 1'b0;
            end else begin
                if (bus.s_rdy != '0) begin
                    checkOutput("rdy_expected", curActive, 1);
                    if (curActive) begin
                        if (cur.err) mTimeoutSeen = 1'b1;
                        checkOutput("s_rdy", bus.s_rdy, 1 << cur.idx);
                        checkOutput("s_err", bus.s_err, cur.err ? (1 << cur.idx) : 0);
                        checkOutput("rdy_latency", cyc - reqCycle, cur.lat);
                        checkOutput("timeout_seen", bus.timeout_seen, mTimeoutSeen);
                        checkOutput("busy_done", bus.busy, 0);
                        curActive = 1'b0;
                    end
                end else begin
                    checkOutput("s_err_alone", bus.s_err, 0);
                    if (curActive && !bus.m_req) checkOutput("m_cmd_stable", bus.m_cmd, cur.cmd);
                end
                if (bus.m_req) begin
                    checkOutput("grant_expected", expQ.size() > 0, 1);
                    if (expQ.size() > 0) begin
                        cur = expQ.pop_front();
                        checkOutput("owner", bus.owner, cur.idx);
                        checkOutput("m_cmd", bus.m_cmd, cur.cmd);
                        checkOutput("busy_grant", bus.busy, 1);
                        if (cur.expCycle >= 0) checkOutput("req_latency", cyc, cur.expCycle);
                        curActive = 1'b1;
                        reqCycle  = cyc;
                    end
                end
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_m_req"}, bus.m_req, 0);
        checkOutput({tag, "_m_cmd"}, bus.m_cmd, 0);
        checkOutput({tag, "_s_rdy"}, bus.s_rdy, 0);
        checkOutput({tag, "_s_err"}, bus.s_err, 0);
        checkOutput({tag, "_owner"}, bus.owner, 0);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_timeout_seen"}, bus.timeout_seen, 0);
    endtask

    initial begin
        exp_t  e;
        plan_t p;
        nCompared    = 0;
        nMismatched  = 0;
        mTimeoutSeen = 1'b0;
        mPtr         = 0;
        rstn         = 1'b0;
        bus.s_req    = '0;
        bus.s_cmd    = '0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single request from requester 2 with cmd 2'b10, target answers 3 cycles after m_req.
        applyStimulus(4'b0100, 8'b0010_0000, 0, 0, 2'b00, 0, 0, 2'b00, 3);
        // All four at once with cmds 0..3 and the fastest legal answer.
        applyStimulus(4'b1111, 8'b1110_0100, 0, 0, 2'b00, 0, 0, 2'b00, 1);
        // Watchdog abort, with requester 0 repeating a different cmd while pending.
        applyStimulus(4'b0011, 8'b0000_0110, 0, 0, 2'b00, 1, 0, 2'b01, -1);
        // Answer landing on the last watchdog cycle completes normally.
        applyStimulus(4'b1001, 8'b0100_0011, 1, 2, 2'b10, 0, 0, 2'b00, TIMEOUT - 1);

        for (int r = 0; r < 30; r++) begin
            rBatch = 4'($urandom_range(1, 15));
            rCmds  = 8'($urandom);
            rInj   = (rBatch != 4'b1111) && ($urandom_range(0, 1) == 1);
            do rInjIdx = int'($urandom_range(0, 3)); while (rBatch[rInjIdx] && rBatch != 4'b1111);
            rInjCmd = 2'($urandom);
            rViol   = ($urandom_range(0, 1) == 1);
            do rViolIdx = int'($urandom_range(0, 3)); while (!rBatch[rViolIdx]);
            rViolCmd = ~rCmds[rViolIdx*2 +: 2];
            applyStimulus(rBatch, rCmds, rInj, rInjIdx, rInjCmd, rViol, rViolIdx, rViolCmd, 0);
        end

        // Reset while requester 1 waits on a silent target: no completion may follow.
        e.idx = pickNext(4'b0010, mPtr);
        e.cmd = 3; e.err = 1'b1; e.lat = TIMEOUT; e.expCycle = -1;
        p.stall = 1'b1; p.delay = 1;
        expQ.push_back(e);
        planQ.push_back(p);
        @(negedge clk);
        bus.s_req = 4'b0010;
        bus.s_cmd = 8'b0000_1100;
        @(negedge clk);
        bus.s_req = 4'b0000;
        waitN = 0;
        while (!curActive && waitN < 20) begin
            @(negedge clk);
            waitN++;
        end
        checkOutput("reset_setup_bound", waitN < 20, 1);
        repeat (2) @(negedge clk);
        checkOutput("busy_before_reset", bus.busy, 1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkResetValues("midreset");
        expQ.delete();
        planQ.delete();
        mPtr = 0;
        mTimeoutSeen = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (12) @(negedge clk);
        applyStimulus(4'b1000, 8'b0100_0000, 0, 0, 2'b00, 0, 0, 2'b00, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
